// File: rtl/zcu102_clk_pkg.sv
// -----------------------------------------------------------------------------
// zcu102_clk_pkg
// Shared definitions for the ADC clock/reset sequencing logic.
//   seq_state_e            : sequencer state encoding (also driven out on seq_state)
//   DEF_SYNC_STAGES        : default depth of the mmcm_locked synchronizer
//   DEF_LOCK_STABLE_CYCLES : default cycles lock must stay high before HOLD
//   DEF_RST_HOLD_CYCLES    : default cycles user_rst is held after lock qualifies
//   max_int()              : larger of two integers, for sizing counters
// -----------------------------------------------------------------------------
package zcu102_clk_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } seq_state_e;

   localparam int DEF_SYNC_STAGES        = 3;
   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_RST_HOLD_CYCLES    = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : zcu102_clk_pkg

// File: rtl/cdc_sync_bit.sv
// -----------------------------------------------------------------------------
// cdc_sync_bit
// Multi-flop synchronizer bringing one asynchronous level into the clk_i domain.
// Ports:
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset, clears every stage to 0
//   d_i    : asynchronous input level
//   q_o    : synchronized level, STAGES cycles behind d_i
// -----------------------------------------------------------------------------
module cdc_sync_bit #(
   parameter int STAGES = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   // ASYNC_REG keeps the chain packed in one slice and out of retiming.
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

   // NOTE: clocked state is always written with non-blocking assignments so
   // every flop samples the pre-edge value of its neighbour.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule : cdc_sync_bit

// File: rtl/adc_clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// adc_clk_rst_sequencer
// Brings the ADC clock domain out of reset once the MMCM has locked and stayed
// locked for a while, then holds user_rst a few more cycles before RUN.
// Any loss of lock drops back to WAIT_LOCK; a software request in RUN replays
// only the reset-hold phase.
// Ports:
//   adc_clk       : sole clock (BUFG-driven MMCM output)
//   adc_rst       : synchronous active-high reset
//   mmcm_locked   : MMCM lock, asynchronous to adc_clk
//   sw_rst_req    : single-cycle software reset request, honoured only in RUN
//   user_rst      : registered active-high reset for downstream logic
//   sys_ready     : registered, high only in RUN
//   lock_loss_cnt : saturating count of synchronized lock 1->0 transitions
//   seq_state     : current state register
// -----------------------------------------------------------------------------
module adc_clk_rst_sequencer
   import zcu102_clk_pkg::*;
#(
   parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES
) (
   input  logic        adc_clk,
   input  logic        adc_rst,
   input  logic        mmcm_locked,
   input  logic        sw_rst_req,
   output logic        user_rst,
   output logic        sys_ready,
   output logic [15:0] lock_loss_cnt,
   output logic [1:0]  seq_state
);

   // One dwell counter serves both timed phases, so it is sized for the longer.
   localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES) + 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             locked_s;
   logic             locked_prev_q;
   logic             lock_fall;
   logic [15:0]      lock_loss_cnt_q;
   logic             user_rst_q;
   logic             sys_ready_q;

   cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk_i (adc_clk),
      .rst_i (adc_rst),
      .d_i   (mmcm_locked),
      .q_o   (locked_s)
   );

   assign lock_fall = locked_prev_q & ~locked_s;

   // NOTE: every output of this block is given a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         WAIT_LOCK: begin
            if (locked_s) state_d = STABLE;
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HOLD: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         RUN: begin
            // Lock loss outranks a coincident software request.
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (sw_rst_req) begin
               state_d = HOLD;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         state_q         <= WAIT_LOCK;
         cnt_q           <= '0;
         locked_prev_q   <= 1'b0;
         lock_loss_cnt_q <= '0;
         user_rst_q      <= 1'b1;
         sys_ready_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         locked_prev_q <= locked_s;
         if (lock_fall && (lock_loss_cnt_q != 16'hFFFF)) begin
            lock_loss_cnt_q <= lock_loss_cnt_q + 16'd1;
         end
         // Registered from next-state so the reset flop changes with the state.
         user_rst_q  <= (state_d != RUN);
         sys_ready_q <= (state_d == RUN);
      end
   end

   assign user_rst      = user_rst_q;
   assign sys_ready     = sys_ready_q;
   assign lock_loss_cnt = lock_loss_cnt_q;
   assign seq_state     = state_q;

endmodule : adc_clk_rst_sequencer

// File: doc/adc_clk_rst_sequencer.md
ADC_CLK_RST_SEQUENCER -- requirements
Module: adc_clk_rst_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 3, number of mmcm_locked synchronizer flops (legal >= 2).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, cycles lock must stay high before the reset-hold phase (legal >= 1).
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 16, cycles user_rst stays asserted after lock qualifies (legal >= 1).
REQ-004 SHALL have port adc_clk  input  1  sole clock, BUFG-driven MMCM output.
REQ-005 SHALL have port adc_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mmcm_locked  input  1  MMCM lock, asynchronous to adc_clk.
REQ-007 SHALL have port sw_rst_req  input  1  single-cycle software reset request.
REQ-008 SHALL have port user_rst  output  1  registered active-high reset for downstream adc_clk logic.
REQ-009 SHALL have port sys_ready  output  1  registered, high only in RUN.
REQ-010 SHALL have port lock_loss_cnt  output  16  saturating count of lock-loss events.
REQ-011 SHALL have port seq_state  output  2  current FSM state encoding.

Function
REQ-012 SHALL pass mmcm_locked through SYNC_STAGES flops; result is locked_s.
REQ-013 SHALL implement FSM states WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
REQ-014 WAIT_LOCK: locked_s=1 -> STABLE next edge, dwell counter cleared.
REQ-015 STABLE: counter increments each cycle; locked_s=0 -> WAIT_LOCK; counter==LOCK_STABLE_CYCLES-1 -> HOLD, counter cleared.
REQ-016 HOLD: counter increments each cycle; locked_s=0 -> WAIT_LOCK; counter==RST_HOLD_CYCLES-1 -> RUN.
REQ-017 RUN: locked_s=0 -> WAIT_LOCK; else sw_rst_req=1 -> HOLD, counter cleared.
REQ-018 Lock loss and sw_rst_req in the same RUN cycle: lock loss wins -> WAIT_LOCK.
REQ-019 sw_rst_req outside RUN SHALL be ignored (no effect, not queued).
REQ-020 user_rst SHALL be registered from next-state: 0 exactly when state is RUN, else 1; sys_ready is its complement.
REQ-021 Latency: first locked_s high on edge k -> STABLE at k+1, HOLD at k+1+LOCK_STABLE_CYCLES, RUN and user_rst=0 at k+1+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES.
REQ-022 lock_loss_cnt SHALL increment by 1 on every 1->0 transition of locked_s in any state; saturate at 0xFFFF, no wrap.
REQ-023 Dwell counter width SHALL be $clog2 of max(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES)+1; no overflow path.
REQ-024 seq_state SHALL equal the state register.

Reset
REQ-025 adc_rst=1 at any edge SHALL force state WAIT_LOCK, dwell counter 0, synchronizer flops 0, locked_s edge-history 0, lock_loss_cnt 0, user_rst 1, sys_ready 0, including mid-sequence.
REQ-026 First locked_s rise after reset SHALL NOT count as lock loss; reset SHALL not itself increment lock_loss_cnt.

Structure
REQ-027 State enum typedef and default parameter constants SHALL live in shared package zcu102_clk_pkg.
REQ-028 Synchronizer SHALL be sub-module cdc_sync_bit (parameter STAGES, ASYNC_REG attribute on flops); all else in this module.

Verification (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4)
REQ-029 Reset release, mmcm_locked=1 from edge 0 -> locked_s edge 2, STABLE edge 3, HOLD edge 11, RUN/user_rst=0/sys_ready=1 edge 15.
REQ-030 Lock drops during STABLE (counter=5) -> WAIT_LOCK, lock_loss_cnt=1, full 8+4 sequence restarts on relock.
REQ-031 In RUN, sw_rst_req pulse -> HOLD next edge, user_rst=1 for exactly 4 cycles, back to RUN; lock_loss_cnt unchanged.
REQ-032 In RUN, sw_rst_req and locked_s fall same cycle -> WAIT_LOCK, lock_loss_cnt +1.
REQ-033 Force 65537 lock-loss events -> lock_loss_cnt holds 0xFFFF.
REQ-034 adc_rst asserted during HOLD -> next edge WAIT_LOCK, user_rst=1, lock_loss_cnt=0.
